i2c_slave_regs: RTL and testbench



---
 rtl/i2c_slave_regs_if.sv | 23 ++
 rtl/i2c_slave_regs.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// Bundle of I2C line levels and register-strobe signals between the target and its host logic.
// The slave modport is the target's view; master is the view of whoever drives the bus.
interface i2c_slave_regs_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda;
  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we;
  logic       o_reg_re;
  logic [7:0] i_reg_rdata;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_reg_rdata,
    output o_sda, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy
  );

  modport master (
    output i_scl, i_sda, i_reg_rdata,
    input  o_sda, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 256 x 8 register space through one-cycle write/read strobes.
// SCL/SDA are synchronized and glitch-filtered; all protocol decisions use the filtered levels.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDRESS   = 7'h50,
  parameter int         FILTER_CYCLES   = 3,
  parameter int         SDA_HOLD_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  i2c_slave_regs_if.slave bus
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int HW = $clog2(SDA_HOLD_CYCLES + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ADDR       = 4'd1;
  localparam logic [3:0] S_ADDR_ACK   = 4'd2;
  localparam logic [3:0] S_REG        = 4'd3;
  localparam logic [3:0] S_REG_ACK    = 4'd4;
  localparam logic [3:0] S_WDATA      = 4'd5;
  localparam logic [3:0] S_WDATA_ACK  = 4'd6;
  localparam logic [3:0] S_RDATA_LOAD = 4'd7;
  localparam logic [3:0] S_RDATA      = 4'd8;
  localparam logic [3:0] S_RDATA_ACK  = 4'd9;
  localparam logic [3:0] S_IGNORE     = 4'd10;

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;
  assign raw_lines = {bus.i_scl, bus.i_sda};

  // Index 1 is SCL, index 0 is SDA; idle lines are high so everything resets to 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic          meta_q, sync_q, filt_q;
    logic [FW-1:0] cnt_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        meta_q <= 1'b1;
        sync_q <= 1'b1;
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else begin
        meta_q <= raw_lines[gi];
        sync_q <= meta_q;
        if (sync_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FW'(FILTER_CYCLES - 1)) begin
          filt_q <= sync_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
    assign filt_lines[gi] = filt_q;
  end

  logic          scl_f, sda_f;
  logic          scl_prev_q, sda_prev_q;
  logic [3:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d, re_q, re_d;
  logic          busy_q, busy_d, rw_q, rw_d;
  logic          sda_out_q, sda_out_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          scl_rise, scl_fall, start_det, stop_det, hold_tick;
  logic [7:0]    rx_byte;

  assign scl_f     = filt_lines[1];
  assign sda_f     = filt_lines[0];
  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign hold_tick = (hold_q == HW'(1));
  assign rx_byte   = {shift_q[6:0], sda_f};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    sda_out_d  = sda_out_q;
    hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
      hold_d    = '0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
      hold_d    = '0;
    end else begin
      if (scl_fall) hold_d = HW'(SDA_HOLD_CYCLES);

      // Output changes only at the hold point after an SCL fall.
      if (hold_tick) begin
        sda_out_d = 1'b1;
        if ((state_q == S_ADDR_ACK || state_q == S_REG_ACK || state_q == S_WDATA_ACK)
            && bit_cnt_q == 4'd0) begin
          sda_out_d = 1'b0;
        end else if (state_q == S_RDATA && bit_cnt_q < 4'd8) begin
          sda_out_d = shift_q[7];
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDRESS) begin
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                  state_d = S_ADDR_ACK;
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_REG) begin
                reg_addr_d = rx_byte;
                state_d    = S_REG_ACK;
              end else begin
                wdata_d = rx_byte;
                we_d    = 1'b1;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd1;
          if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (state_q == S_ADDR_ACK) begin
              state_d = rw_q ? S_RDATA_LOAD : S_REG;
              re_d    = rw_q;
            end else begin
              if (state_q == S_WDATA_ACK) reg_addr_d = reg_addr_q + 8'd1;
              state_d = S_WDATA;
            end
          end
        end
        S_RDATA_LOAD: begin
          shift_d   = bus.i_reg_rdata;
          bit_cnt_d = '0;
          state_d   = S_RDATA;
        end
        S_RDATA: begin
          if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            state_d   = S_RDATA_ACK;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_d = S_IGNORE;
            else       bit_cnt_d = 4'd1;
          end
          if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d  = '0;
            reg_addr_d = reg_addr_q + 8'd1;
            re_d       = 1'b1;
            state_d    = S_RDATA_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_out_q  <= 1'b1;
      hold_q     <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      sda_out_q  <= sda_out_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.o_sda       = sda_out_q;
  assign bus.o_reg_addr  = reg_addr_q;
  assign bus.o_reg_wdata = wdata_q;
  assign bus.o_reg_we    = we_q;
  assign bus.o_reg_re    = re_q;
  assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: a bit-banged I2C master drives the target; strobes are logged and compared
// against hand-computed transactions.
module tb_i2c_slave_regs;
  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] rd_value = 8'h00;
  logic       glitch_en = 1'b0;
  logic       busy_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];

  i2c_slave_regs_if bus ();
  assign bus.i_scl       = scl_m;
  assign bus.i_sda       = sda_m & bus.o_sda;
  assign bus.i_reg_rdata = rd_value;

  i2c_slave_regs #(.SLAVE_ADDRESS(7'h50), .FILTER_CYCLES(3), .SDA_HOLD_CYCLES(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_reg_we) we_log.push_back({bus.o_reg_addr, bus.o_reg_wdata});
    if (bus.o_reg_re) re_log.push_back(bus.o_reg_addr);
    if (bus.o_busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    if (glitch_en) begin
      wait_cyc(Q / 2);
      scl_m = 1'b1;
      wait_cyc(1);
      scl_m = 1'b0;
      wait_cyc(Q - Q / 2 - 1);
    end else begin
      wait_cyc(Q);
    end
    scl_m = 1'b1;
    wait_cyc(Q);
    if (glitch_en) begin
      sda_m = ~b;
      wait_cyc(1);
      sda_m = b;
      wait_cyc(Q - 1);
    end else begin
      wait_cyc(Q);
    end
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_cyc(Q);
    b = bus.i_sda;
    wait_cyc(Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  task automatic clear_logs();
    we_log.delete();
    re_log.delete();
    busy_seen = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    wait_cyc(5);
    check("rst_sda", bus.o_sda, 1);
    check("rst_addr", bus.o_reg_addr, 8'h00);
    check("rst_wdata", bus.o_reg_wdata, 8'h00);
    check("rst_we", bus.o_reg_we, 0);
    check("rst_re", bus.o_reg_re, 0);
    check("rst_busy", bus.o_busy, 0);
    rst = 1'b0;
    wait_cyc(10);

    // Single write: reg 12 <= A5
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); check("w1_ack_addr", ack, 0);
    write_byte(8'h12, ack); check("w1_ack_reg", ack, 0);
    check("w1_busy_mid", bus.o_busy, 1);
    write_byte(8'hA5, ack); check("w1_ack_data", ack, 0);
    i2c_stop();
    wait_cyc(Q);
    check("w1_busy_after_stop", bus.o_busy, 0);
    check("w1_we_count", we_log.size(), 1);
    check("w1_we_entry", we_log[0], 16'h12A5);

    // Read reg 34 returning 5A, master NACK
    clear_logs();
    rd_value = 8'h5A;
    i2c_start();
    write_byte(8'hA0, ack); check("r1_ack_addr_w", ack, 0);
    write_byte(8'h34, ack); check("r1_ack_reg", ack, 0);
    i2c_rstart();
    write_byte(8'hA1, ack); check("r1_ack_addr_r", ack, 0);
    read_byte(d);           check("r1_data", d, 8'h5A);
    write_bit(1'b1);
    check("r1_sda_released", bus.o_sda, 1);
    i2c_stop();
    wait_cyc(Q);
    check("r1_re_count", re_log.size(), 1);
    check("r1_re_addr", re_log[0], 8'h34);
    check("r1_no_we", we_log.size(), 0);

    // Burst write with pointer wrap FE, FF, 00
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); check("b_ack_addr", ack, 0);
    write_byte(8'hFE, ack); check("b_ack_reg", ack, 0);
    write_byte(8'h11, ack); check("b_ack_d0", ack, 0);
    write_byte(8'h22, ack); check("b_ack_d1", ack, 0);
    write_byte(8'h33, ack); check("b_ack_d2", ack, 0);
    i2c_stop();
    wait_cyc(Q);
    check("b_we_count", we_log.size(), 3);
    check("b_we_0", we_log[0], 16'hFE11);
    check("b_we_1", we_log[1], 16'hFF22);
    check("b_we_2", we_log[2], 16'h0033);

    // Wrong address 51 is NACKed and ignored
    clear_logs();
    i2c_start();
    write_byte(8'hA2, ack); check("m_nack_addr", ack, 1);
    write_byte(8'h21, ack); check("m_nack_reg", ack, 1);
    i2c_stop();
    wait_cyc(Q);
    check("m_busy_never", busy_seen, 0);
    check("m_no_we", we_log.size(), 0);
    check("m_no_re", re_log.size(), 0);

    // Following transaction to 50 is served
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); check("m2_ack_addr", ack, 0);
    write_byte(8'h21, ack); check("m2_ack_reg", ack, 0);
    write_byte(8'h3C, ack); check("m2_ack_data", ack, 0);
    i2c_stop();
    wait_cyc(Q);
    check("m2_we_count", we_log.size(), 1);
    check("m2_we_entry", we_log[0], 16'h213C);

    // One-cycle glitches on both lines during the data byte
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); check("g_ack_addr", ack, 0);
    write_byte(8'h60, ack); check("g_ack_reg", ack, 0);
    glitch_en = 1'b1;
    write_byte(8'hC3, ack);
    glitch_en = 1'b0;
    check("g_ack_data", ack, 0);
    check("g_busy_held", bus.o_busy, 1);
    i2c_stop();
    wait_cyc(Q);
    check("g_we_count", we_log.size(), 1);
    check("g_we_entry", we_log[0], 16'h60C3);

    // Reset while the target is driving a 0 data bit
    clear_logs();
    rd_value = 8'h00;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h70, ack);
    i2c_rstart();
    write_byte(8'hA1, ack); check("x_ack_addr_r", ack, 0);
    check("x_sda_driven_low", bus.o_sda, 0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("x_sda_released", bus.o_sda, 1);
    check("x_busy_cleared", bus.o_busy, 0);
    wait_cyc(Q);
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); check("x2_ack_addr", ack, 0);
    write_byte(8'h40, ack); check("x2_ack_reg", ack, 0);
    write_byte(8'h77, ack); check("x2_ack_data", ack, 0);
    i2c_stop();
    wait_cyc(Q);
    check("x2_we_count", we_log.size(), 1);
    check("x2_we_entry", we_log[0], 16'h4077);
    check("x2_no_re", re_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
